// File: rtl/device_bridge_pkg.sv
// rtl/device_bridge_pkg.sv - shared types and constants for the CPU-to-device bridge
package device_bridge_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   localparam logic MODE_READ  = 1'b1;
   localparam logic MODE_WRITE = 1'b0;

endpackage

// File: rtl/device_bridge_if.sv
// rtl/device_bridge_if.sv - CPU transaction bus and point-to-point device channels
interface device_bridge_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 5
);
   localparam int N = 1 << ADDR_WIDTH;

   logic [ADDR_WIDTH-1:0]          address;
   logic                           enable;
   logic                           mode;
   logic [DATA_WIDTH-1:0]          data_in;
   logic                           busy;
   logic                           done;
   logic                           error;
   logic [N-1:0]                   dev_req;
   logic                           dev_we;
   logic [DATA_WIDTH-1:0]          dev_wdata;
   logic [N-1:0][DATA_WIDTH-1:0]   dev_rdata;
   logic [N-1:0]                   dev_ack;

   // master: CPU plus device side; slave: the bridge itself
   modport master (
      output address, enable, mode, data_in, dev_rdata, dev_ack,
      input  busy, done, error, dev_req, dev_we, dev_wdata
   );

   modport slave (
      input  address, enable, mode, data_in, dev_rdata, dev_ack,
      output busy, done, error, dev_req, dev_we, dev_wdata
   );

endinterface

// File: rtl/device_bridge_timeout.sv
// rtl/device_bridge_timeout.sv - bounded-wait counter; expired marks the last permitted wait edge
module device_bridge_timeout #(
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic tick,
   output logic expired
);

   generate
      if (TIMEOUT_CYCLES == 0) begin : g_forever
         assign expired = 1'b0;
      end else begin : g_count
         localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
         localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

         logic [CW-1:0] count;

         // saturates at LAST so the count can never wrap back to zero
         always_ff @(negedge clk) begin
            if (rst) begin
               count <= '0;
            end else if (clear) begin
               count <= '0;
            end else if (tick && (count != LAST)) begin
               count <= count + 1'b1;
            end
         end

         assign expired = (count == LAST);
      end
   endgenerate

endmodule

// File: rtl/device_bridge.sv
// rtl/device_bridge.sv - maps one CPU transaction onto a req/ack device channel; state updates on the falling clock edge
module device_bridge
   import device_bridge_pkg::*;
#(
   parameter int                          DATA_WIDTH     = 8,
   parameter int                          ADDR_WIDTH     = 5,
   parameter logic [(1<<ADDR_WIDTH)-1:0]  WRITABLE_MASK  = '1,
   parameter int                          TIMEOUT_CYCLES = 15,
   parameter logic [DATA_WIDTH-1:0]       TIMEOUT_DATA   = '1
) (
   input  logic                  clk,
   input  logic                  rst,
   device_bridge_if.slave        bus,
   output logic [DATA_WIDTH-1:0] data_out
);

   localparam int N = 1 << ADDR_WIDTH;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [N-1:0]            req_q, req_d;
   logic                    we_q, we_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    error_q, error_d;
   logic [DATA_WIDTH-1:0]   value_q, value_d;
   logic                    clear, tick, expired;

   device_bridge_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   (clear),
      .tick    (tick),
      .expired (expired)
   );

   always_ff @(negedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         req_q   <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
         value_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         req_q   <= req_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         error_q <= error_d;
         value_q <= value_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      req_d   = req_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      error_d = error_q;
      value_d = value_q;
      clear   = 1'b0;
      tick    = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.enable) begin
               if ((bus.mode == MODE_WRITE) && !WRITABLE_MASK[bus.address]) begin
                  // protected write is refused without touching the channel
                  error_d = 1'b1;
                  done_d  = 1'b1;
               end else begin
                  addr_d              = bus.address;
                  we_d                = (bus.mode == MODE_WRITE);
                  wdata_d             = bus.data_in;
                  req_d               = '0;
                  req_d[bus.address]  = 1'b1;
                  busy_d              = 1'b1;
                  error_d             = 1'b0;
                  clear               = 1'b1;
                  state_d             = WAIT;
               end
            end
         end
         WAIT: begin
            // ack is tested first so it wins over a timeout on the same edge
            if (bus.dev_ack[addr_q]) begin
               if (!we_q) value_d = bus.dev_rdata[addr_q];
               req_d   = '0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = IDLE;
            end else if (expired) begin
               if (!we_q) value_d = TIMEOUT_DATA;
               req_d   = '0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               error_d = 1'b1;
               state_d = IDLE;
            end else begin
               tick = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.dev_req   = req_q;
   assign bus.dev_we    = we_q;
   assign bus.dev_wdata = wdata_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.error     = error_q;
   assign data_out      = (bus.enable && (bus.mode == MODE_READ)) ? value_q : 'z;

endmodule

// File: tb/tb_device_bridge.sv
// tb/tb_device_bridge.sv - randomized scoreboard bench for device_bridge
module tb_device_bridge;

   localparam int DW = 8;
   localparam int AW = 5;
   localparam int N  = 1 << AW;
   localparam int T  = 4;
   localparam logic [N-1:0] MASK = 32'hFFFF_FFFB;

   typedef struct {
      bit            rd;
      logic [DW-1:0] data;
      logic          err;
   } exp_t;

   logic          clk;
   logic          rst;
   wire  [DW-1:0] data_out;
   int            tests = 0;
   int            fails = 0;
   exp_t          sb[$];
   exp_t          mon_e;
   logic [DW-1:0] model_val = '0;

   device_bridge_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   device_bridge #(
      .DATA_WIDTH     (DW),
      .ADDR_WIDTH     (AW),
      .WRITABLE_MASK  (MASK),
      .TIMEOUT_CYCLES (T),
      .TIMEOUT_DATA   (8'hFF)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .data_out (data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: every completion pulse consumes one scoreboard entry
   always @(posedge clk) begin
      if (!rst && bus.done === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            check("done_error", bus.error, mon_e.err);
            if (mon_e.rd) check("read_data", data_out, mon_e.data);
         end
      end
   end

   // entered and left at posedge+2; ack_at = wait edge carrying ack (0 = never), wrong = stray ack channel or -1
   task automatic do_txn(input int addr, input bit rd, input logic [DW-1:0] wd,
                         input int ack_at, input logic [DW-1:0] rv, input int wrong);
      bit           prot;
      exp_t         e;
      int           expect_edges;
      int           k;
      logic [N-1:0] onehot;
      prot   = !rd && !MASK[addr];
      onehot = '0;
      if (!prot) onehot[addr] = 1'b1;
      for (int c = 0; c < N; c++) bus.dev_rdata[c] = 8'($urandom);
      bus.dev_rdata[addr] = rv;
      bus.address = addr[AW-1:0];
      bus.mode    = rd;
      bus.data_in = wd;
      bus.dev_ack = '0;
      bus.enable  = 1'b1;
      #1;
      if (rd) check("held_value", data_out, model_val);
      e.rd = rd;
      if (prot) begin
         e.err = 1'b1;
         expect_edges = 0;
      end else if (ack_at >= 1 && ack_at <= T) begin
         e.err = 1'b0;
         expect_edges = ack_at;
         if (rd) model_val = rv;
      end else begin
         e.err = 1'b1;
         expect_edges = T;
         if (rd) model_val = 8'hFF;
      end
      e.data = model_val;
      sb.push_back(e);
      @(posedge clk);
      check("dev_req", bus.dev_req, onehot);
      check("busy", bus.busy, !prot);
      if (!prot) check("error_cleared", bus.error, 0);
      k = 0;
      while (bus.done !== 1'b1 && k < 40) begin
         check("req_held", bus.dev_req, onehot);
         check("dev_we", bus.dev_we, !rd);
         check("dev_wdata", bus.dev_wdata, wd);
         #2;
         k++;
         bus.dev_ack = '0;
         if (k == ack_at) bus.dev_ack[addr] = 1'b1;
         if (wrong >= 0) bus.dev_ack[wrong] = 1'b1;
         @(posedge clk);
      end
      check("done_seen", bus.done, 1);
      check("latency", k, expect_edges);
      check("req_dropped", bus.dev_req, 0);
      check("busy_dropped", bus.busy, 0);
      #2;
      bus.enable  = 1'b0;
      bus.dev_ack = '0;
      @(posedge clk);
      check("done_pulse", bus.done, 0);
      check("error_held", bus.error, e.err);
      #2;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int addr, wrong;
      rst         = 1'b1;
      bus.enable  = 1'b0;
      bus.address = '0;
      bus.mode    = 1'b0;
      bus.data_in = '0;
      bus.dev_ack = '0;
      bus.dev_rdata = '0;
      repeat (2) @(posedge clk);
      check("rst_req", bus.dev_req, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_error", bus.error, 0);
      check("rst_we", bus.dev_we, 0);
      check("rst_wdata", bus.dev_wdata, 0);
      #2;
      bus.mode   = 1'b1;
      bus.enable = 1'b1;
      #1;
      check("rst_value", data_out, 0);
      bus.enable = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b0;
      @(posedge clk);
      #2;

      do_txn(3, 1'b1, 8'h00, 1, 8'hA5, -1);
      do_txn(7, 1'b0, 8'h3C, 3, 8'h11, -1);
      do_txn(2, 1'b0, 8'h55, 1, 8'h22, -1);
      do_txn(9, 1'b1, 8'h00, 0, 8'h33, -1);
      do_txn(4, 1'b1, 8'h00, 2, 8'h6E, -1);
      do_txn(5, 1'b1, 8'h00, 0, 8'h44, 1);
      do_txn(5, 1'b1, 8'h00, T, 8'h5A, 1);

      // reset while a read is pending
      bus.address = 5'd11;
      bus.mode    = 1'b1;
      bus.dev_ack = '0;
      bus.enable  = 1'b1;
      @(posedge clk);
      check("mid_busy", bus.busy, 1);
      #2;
      bus.dev_ack[11] = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b1;
      @(posedge clk);
      check("mid_req", bus.dev_req, 0);
      check("mid_busy_clr", bus.busy, 0);
      check("mid_done", bus.done, 0);
      #1;
      check("mid_value", data_out, 0);
      model_val = '0;
      #1;
      bus.enable = 1'b0;
      @(posedge clk);
      check("mid_done2", bus.done, 0);
      #2;
      rst = 1'b0;
      @(posedge clk);
      #2;
      do_txn(11, 1'b1, 8'h00, 2, 8'hC3, -1);

      for (int i = 0; i < 40; i++) begin
         addr  = $urandom_range(0, N-1);
         wrong = ($urandom_range(0, 2) == 0) ? (addr + 1 + $urandom_range(0, N-2)) % N : -1;
         do_txn(addr, 1'($urandom), 8'($urandom), $urandom_range(0, 6), 8'($urandom), wrong);
      end

      check("scoreboard_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
